// File: rtl/piradip_axis_sample_deinterleaver.sv
`timescale 1ns/1ps
// piradip_axis_sample_deinterleaver
//
// Splits one interleaved IQ AXI4-Stream into separate I and Q AXI4-Streams.
// The operating mode is taken from {i_en, q_en}:
//   BOTH   : even samples of each input beat go to I, odd samples go to Q,
//            one output beat per channel per input beat.
//   I_ONLY : an input beat carries I samples only; it leaves as two
//   Q_ONLY   half-width beats (low half first) on the selected channel.
//   NONE   : input is accepted and discarded, drop_count counts the beats.
// The mode is only re-sampled when both outputs and the pending half-beat
// register are empty, so a beat is never split across two modes.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   i_en, q_en            channel enables (select the mode)
//   iq_t*                 interleaved input stream (IN_WIDTH data)
//   i_t*, q_t*            per-channel output streams (IN_WIDTH/2 data)
//   drop_count            saturating count of beats dropped in NONE mode
module piradip_axis_sample_deinterleaver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int IN_WIDTH     = 128
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     i_en,
  input  logic                     q_en,
  input  logic [IN_WIDTH-1:0]      iq_tdata,
  input  logic                     iq_tvalid,
  input  logic                     iq_tlast,
  output logic                     iq_tready,
  output logic [IN_WIDTH/2-1:0]    i_tdata,
  output logic                     i_tvalid,
  output logic                     i_tlast,
  input  logic                     i_tready,
  output logic [IN_WIDTH/2-1:0]    q_tdata,
  output logic                     q_tvalid,
  output logic                     q_tlast,
  input  logic                     q_tready,
  output logic [31:0]              drop_count
);

  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int N_SAMP    = IN_WIDTH / SAMPLE_WIDTH;

  // Mode encoding matches {i_en, q_en} so reload is a direct copy.
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_Q    = 2'b01;
  localparam logic [1:0] MODE_I    = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Single-channel sequencer: LOW = pending empty, HIGH = upper half waiting.
  localparam logic [0:0] SEQ_LOW  = 1'b0;
  localparam logic [0:0] SEQ_HIGH = 1'b1;

  generate
    if ((IN_WIDTH % (2 * SAMPLE_WIDTH)) != 0 || (OUT_WIDTH * 2) != IN_WIDTH) begin : g_bad_cfg
      $error("IN_WIDTH must be a multiple of 2*SAMPLE_WIDTH");
    end
  endgenerate

  logic [1:0]           mode_q, mode_d;
  logic [0:0]           seq_q, seq_d;
  logic [OUT_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                 pend_last_q, pend_last_d;
  logic [OUT_WIDTH-1:0] i_data_q, i_data_d;
  logic                 i_valid_q, i_valid_d;
  logic                 i_last_q, i_last_d;
  logic [OUT_WIDTH-1:0] q_data_q, q_data_d;
  logic                 q_valid_q, q_valid_d;
  logic                 q_last_q, q_last_d;
  logic [31:0]          drop_cnt_q, drop_cnt_d;

  logic                 i_load, q_load, sel_load;
  logic                 idle, ready, xfer;
  logic [OUT_WIDTH-1:0] even_s, odd_s;
  logic                 half_fire, half_last;
  logic [OUT_WIDTH-1:0] half_data;

  assign i_load   = ~i_valid_q | i_tready;
  assign q_load   = ~q_valid_q | q_tready;
  assign sel_load = (mode_q == MODE_I) ? i_load : q_load;
  assign idle     = ~i_valid_q & ~q_valid_q & (seq_q == SEQ_LOW);

  always_comb begin
    ready = 1'b1;
    case (mode_q)
      MODE_BOTH: ready = i_load & q_load;
      MODE_I:    ready = (seq_q == SEQ_LOW) & i_load;
      MODE_Q:    ready = (seq_q == SEQ_LOW) & q_load;
      default:   ready = 1'b1;
    endcase
  end

  // Hold off the source for the whole time reset is asserted.
  assign iq_tready = ready & ~areset;
  assign xfer      = iq_tvalid & iq_tready;

  // Sample 2k goes to I lane k, sample 2k+1 goes to Q lane k.
  always_comb begin
    even_s = '0;
    odd_s  = '0;
    for (int k = 0; k < N_SAMP / 2; k++) begin
      even_s[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = iq_tdata[(2*k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      odd_s[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]  = iq_tdata[(2*k+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  always_comb begin
    mode_d      = mode_q;
    seq_d       = seq_q;
    pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;
    i_data_d    = i_data_q;
    i_last_d    = i_last_q;
    i_valid_d   = i_valid_q & ~i_tready;
    q_data_d    = q_data_q;
    q_last_d    = q_last_q;
    q_valid_d   = q_valid_q & ~q_tready;
    drop_cnt_d  = drop_cnt_q;
    half_fire   = 1'b0;
    half_data   = '0;
    half_last   = 1'b0;

    if (idle) begin
      mode_d = {i_en, q_en};
    end

    case (mode_q)
      MODE_BOTH: begin
        if (xfer) begin
          i_data_d  = even_s;
          i_last_d  = iq_tlast;
          i_valid_d = 1'b1;
          q_data_d  = odd_s;
          q_last_d  = iq_tlast;
          q_valid_d = 1'b1;
        end
      end
      MODE_I, MODE_Q: begin
        if (xfer) begin
          // Low half leaves now; the frame's tlast travels with the high half.
          half_fire   = 1'b1;
          half_data   = iq_tdata[OUT_WIDTH-1:0];
          half_last   = 1'b0;
          pend_data_d = iq_tdata[IN_WIDTH-1:OUT_WIDTH];
          pend_last_d = iq_tlast;
          seq_d       = SEQ_HIGH;
        end else if (seq_q == SEQ_HIGH && sel_load) begin
          half_fire = 1'b1;
          half_data = pend_data_q;
          half_last = pend_last_q;
          seq_d     = SEQ_LOW;
        end
        if (half_fire) begin
          if (mode_q == MODE_I) begin
            i_data_d  = half_data;
            i_last_d  = half_last;
            i_valid_d = 1'b1;
          end else begin
            q_data_d  = half_data;
            q_last_d  = half_last;
            q_valid_d = 1'b1;
          end
        end
      end
      default: begin
        if (xfer && drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_q      <= MODE_NONE;
      seq_q       <= SEQ_LOW;
      pend_data_q <= '0;
      pend_last_q <= 1'b0;
      i_data_q    <= '0;
      i_last_q    <= 1'b0;
      i_valid_q   <= 1'b0;
      q_data_q    <= '0;
      q_last_q    <= 1'b0;
      q_valid_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      seq_q       <= seq_d;
      pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;
      i_data_q    <= i_data_d;
      i_last_q    <= i_last_d;
      i_valid_q   <= i_valid_d;
      q_data_q    <= q_data_d;
      q_last_q    <= q_last_d;
      q_valid_q   <= q_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign i_tdata    = i_data_q;
  assign i_tvalid   = i_valid_q;
  assign i_tlast    = i_last_q;
  assign q_tdata    = q_data_q;
  assign q_tvalid   = q_valid_q;
  assign q_tlast    = q_last_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: doc/piradip_axis_sample_deinterleaver.md
Name: piradip_axis_sample_deinterleaver

Overview:
Splits one interleaved IQ AXI4-Stream into separate I and Q AXI4-Streams. It is the receive-side counterpart of the sample interleaver and sits between the DMA/stream source and the per-channel DAC sample paths. Mode is set by i_en/q_en:
- Both enabled: samples alternate I/Q.
- One enabled: a full-width input beat carries samples of that channel only and is emitted as two half-width beats.
- Neither enabled: input is drained and dropped beats are counted.

Parameters:
SAMPLE_WIDTH, 16, bits per sample
IN_WIDTH, 128, IQ input tdata width; must be a multiple of 2*SAMPLE_WIDTH
OUT_WIDTH, IN_WIDTH/2, I and Q output tdata width (derived, not overridable)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
i_en  in  1  I channel enable
q_en  in  1  Q channel enable
iq_tdata  in  IN_WIDTH  interleaved input data
iq_tvalid  in  1  input valid
iq_tlast  in  1  input last
iq_tready  out  1  input ready
i_tdata  out  OUT_WIDTH  I output data
i_tvalid  out  1  I output valid
i_tlast  out  1  I output last
i_tready  in  1  I output ready
q_tdata  out  OUT_WIDTH  Q output data
q_tvalid  out  1  Q output valid
q_tlast  out  1  Q output last
q_tready  in  1  Q output ready
drop_count  out  32  beats discarded while both channels are disabled

Behaviour:
- Reset (async assert, sync release): all tvalid/tlast=0; tdata=0; pending register empty; mode=NONE; drop_count=0. iq_tready=0 while areset=1.
- Mode register ∈ {BOTH, I_ONLY, Q_ONLY, NONE}. It reloads from {i_en,q_en} only on a cycle where i_tvalid=0, q_tvalid=0 and pending is empty. Otherwise the previous mode holds, so a mode change never splits a beat.
- Input handshake: transfer occurs when iq_tvalid & iq_tready. Output channel c "can load" = ~c_tvalid | c_tready.
- BOTH mode:
  - iq_tready = i can load & q can load.
  - On transfer, one cycle later: i_tdata[k*SW+:SW] = in sample 2k; q_tdata[k*SW+:SW] = in sample 2k+1, for k=0..N/2-1 where N=IN_WIDTH/SW.
  - i_tvalid=q_tvalid=1; both tlast = iq_tlast.
  - Each output clears independently when its own tready=1. Sustained throughput is 1 beat/cycle when both readies are high.
- I_ONLY / Q_ONLY mode: two-state sequencer (LOW/HIGH) with a pending register holding the upper half.
  - iq_tready = pending empty & selected channel can load.
  - On transfer: out <= iq_tdata[OUT_WIDTH-1:0] with tlast=0; pending <= upper half plus saved iq_tlast.
  - Next cycle the selected channel can load: out <= pending; tlast = saved tlast; pending cleared.
  - Throughput is 1 input beat per 2 cycles. The unselected channel holds tvalid=0.
- NONE mode: iq_tready=1. Each transfer is discarded and drop_count increments, saturating at 0xFFFFFFFF. Outputs stay tvalid=0.
- Output stability: while c_tvalid=1 and c_tready=0, tdata/tlast do not change.
- Mode change while data is in flight: the old mode persists until flushed. Example: BOTH → I_ONLY while Q is stalled keeps iq_tready=0 (Q cannot load) until q_tready drains it, then the mode reloads.
- Reset mid-operation: pending data and output beats are lost without notice; drop_count is cleared.
- Elaboration checks: IN_WIDTH % (2*SAMPLE_WIDTH) == 0 and OUT_WIDTH == IN_WIDTH/2.

Test Plan:
1. BOTH: in samples (LSB first) 0x0000..0x0007, tlast=1, readies=1 → after 1 cycle i_tdata samples = 0,2,4,6 and q_tdata samples = 1,3,5,7; both tlast=1; 8 back-to-back beats produce 8 outputs on each channel in 8 consecutive cycles.
2. BOTH backpressure: q_tready=0 for 5 cycles, i_tready=1 → I emits 1 beat then stalls; iq_tready=0 until q_tready=1; no beat is duplicated or lost (scoreboard).
3. I_ONLY: input 0x0007_0006_..._0000 with tlast=1 → i_tdata samples 0,1,2,3 with tlast=0, then samples 4,5,6,7 with tlast=1; q_tvalid stays 0; iq_tready toggles 1,0.
4. Q_ONLY with q_tready toggling 1/0 → output order is low half then high half for 4 input beats; tdata is stable during stalls.
5. NONE: 10 input beats → iq_tready=1 throughout, drop_count=10, no output tvalid; preset counter near max → saturates at 0xFFFFFFFF.
6. Mode switch BOTH→I_ONLY with a stalled Q beat, plus assert areset mid-I_ONLY while pending is full → switch delayed until the Q beat drains; after reset all outputs are 0 and drop_count=0.
